// File: rtl/lcd_bus_writer.sv
// Byte-level write engine for an ST7920-class 12864 LCD in 8-bit parallel mode.
// It generates the LCD reset and power-on wait, then runs setup/enable/hold/exec timing for each accepted byte.
module lcd_bus_writer #(
    parameter int unsigned RST_LOW_CYC  = 500000,
    parameter int unsigned POR_WAIT_CYC = 2000000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_HIGH_CYC  = 24,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 3600,
    parameter int unsigned CLR_WAIT_CYC = 80000,
    parameter int unsigned CNT_W        = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dat,
    output logic       psb,
    output logic       lcd_rst
);

    typedef enum logic [2:0] {
        S_RSTLOW,
        S_PORWAIT,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] L_RST = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] L_POR = CNT_W'(POR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] L_SET = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_EN  = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] L_HLD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_CMD = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] L_CLR = CNT_W'(CLR_WAIT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rs;
    logic             w_rs_nxt;
    logic [7:0]       r_dat;
    logic [7:0]       w_dat_nxt;
    logic             r_en;
    logic             r_ready;
    logic             r_lcd_rst;
    logic             w_hs;
    logic             w_cnt_zero;
    logic             w_is_clear;

    assign w_hs       = in_valid && r_ready;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_is_clear = !r_rs && (r_dat == 8'h01);

    // Reset is treated as entry into RSTLOW, so the counter preloads that state's length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RSTLOW;
            r_cnt     <= L_RST;
            r_rs      <= 1'b0;
            r_dat     <= '0;
            r_en      <= 1'b0;
            r_ready   <= 1'b0;
            r_lcd_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rs      <= w_rs_nxt;
            r_dat     <= w_dat_nxt;
            r_en      <= (w_state_nxt == S_PULSE);
            r_ready   <= (w_state_nxt == S_IDLE);
            r_lcd_rst <= (w_state_nxt != S_RSTLOW);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        w_rs_nxt    = r_rs;
        w_dat_nxt   = r_dat;
        case (r_state)
            S_RSTLOW: if (w_cnt_zero) begin
                w_state_nxt = S_PORWAIT;
                w_cnt_nxt   = L_POR;
            end
            S_PORWAIT: if (w_cnt_zero) begin
                w_state_nxt = S_IDLE;
            end
            S_IDLE: if (w_hs) begin
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = L_SET;
                w_rs_nxt    = in_rs;
                w_dat_nxt   = in_data;
            end
            S_SETUP: if (w_cnt_zero) begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = L_EN;
            end
            S_PULSE: if (w_cnt_zero) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = L_HLD;
            end
            S_HOLD: if (w_cnt_zero) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = w_is_clear ? L_CLR : L_CMD;
            end
            S_WAIT: if (w_cnt_zero) begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_RSTLOW;
                w_cnt_nxt   = L_RST;
            end
        endcase
    end

    assign in_ready = r_ready;
    assign rs       = r_rs;
    assign rw       = 1'b0;
    assign en       = r_en;
    assign dat      = r_dat;
    assign psb      = 1'b1;
    assign lcd_rst  = r_lcd_rst;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: a timeline model predicts every output each cycle from the
// handshake edge plus the setup/enable/hold/wait lengths.
module tb_lcd_bus_writer;

    localparam int RST_LOW = 4;
    localparam int POR     = 10;
    localparam int S       = 2;
    localparam int E       = 3;
    localparam int H       = 1;
    localparam int CMD     = 5;
    localparam int CLR     = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, rs, rw, en, psb, lcd_rst;
    logic [7:0] dat;
    logic [13:0] act;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Model: n is the index of the next rising edge; values sampled just before it form cycle n.
    int         n;
    int         ready_at;
    int         en_lo;
    int         en_hi;
    int         accepts;
    logic       m_rs;
    logic [7:0] m_dat;

    lcd_bus_writer #(
        .RST_LOW_CYC (RST_LOW),
        .POR_WAIT_CYC(POR),
        .SETUP_CYC   (S),
        .EN_HIGH_CYC (E),
        .HOLD_CYC    (H),
        .CMD_WAIT_CYC(CMD),
        .CLR_WAIT_CYC(CLR),
        .CNT_W       (22)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_rs   (in_rs),
        .in_data (in_data),
        .in_ready(in_ready),
        .rs      (rs),
        .rw      (rw),
        .en      (en),
        .dat     (dat),
        .psb     (psb),
        .lcd_rst (lcd_rst)
    );

    always #5 clk = ~clk;

    assign act = {in_ready, rs, rw, en, dat, psb, lcd_rst};

    function automatic logic [13:0] exp_vec();
        return {(n >= ready_at), m_rs, 1'b0, (n >= en_lo && n <= en_hi), m_dat, 1'b1, (n >= RST_LOW)};
    endfunction

    task automatic model_reset();
        n        = 0;
        ready_at = RST_LOW + POR;
        en_lo    = 1;
        en_hi    = 0;
        m_rs     = 1'b0;
        m_dat    = 8'h00;
    endtask

    task automatic model_edge();
        int w;
        if (in_valid && n >= ready_at) begin
            w        = (!in_rs && in_data == 8'h01) ? CLR : CMD;
            en_lo    = n + 1 + S;
            en_hi    = n + S + E;
            ready_at = n + 1 + S + E + H + w;
            m_rs     = in_rs;
            m_dat    = in_data;
            accepts++;
        end
        n++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL power_up cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = 1'b0;
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_data_write();
        for (int i = 0; i < 14; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL data_write cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = (i == 0);
            in_rs    = 1'b1;
            in_data  = 8'h41;
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 44; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_cmd cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = (i == 0) || (i == 29);
            in_rs    = 1'b0;
            in_data  = (i < 29) ? 8'h01 : 8'h30;
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        accepts = 0;
        for (int i = 0; i < 30; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = (accepts < 2);
            in_rs    = 1'b0;
            in_data  = (accepts == 0) ? 8'h0C : 8'h06;
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        for (int i = 0; i < 14; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL busy_ignore cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = (i <= 10);
            in_rs    = (i == 0) ? 1'b1 : 1'($urandom);
            in_data  = (i == 0) ? 8'h55 : 8'($urandom);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) begin
                in_rs   = 1'b0;
                in_data = 8'h01;
            end else begin
                in_rs   = 1'($urandom);
                in_data = 8'($urandom);
            end
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_pulse();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL pre_reset cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = (i == 0);
            in_rs    = 1'b1;
            in_data  = 8'hA7;
            model_edge();
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({en, in_ready, lcd_rst} !== 3'b000) begin
            n_bad++;
            $display("FAIL async_reset: got en/ready/lcd_rst %b expected 000", {en, in_ready, lcd_rst});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++;
                $display("FAIL post_reset cycle %0d: got %h expected %h", n, act, exp_vec());
            end
            in_valid = 1'b0;
            model_edge();
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        accepts = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_reset();
        test_data_write();
        test_clear();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_reset_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
